// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared definitions for the pipeline sequencing controller:
//                address width, the NOP word loaded by flushed stage
//                registers, the controller state type and the load-use
//                hazard detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    // ADDI x0, x0, 0 - what IF/ID and ID/EX load when flushed
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        IMISS       = 2'd1,
        IMISS_REDIR = 2'd2,
        DSTALL      = 2'd3
    } hz_state_e;

    // A load in EX whose destination feeds the instruction now in ID.
    // x0 never carries a dependency.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_uses_rs2
    );
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//                Synchronous reset loads INIT (zero unless overridden).
//  Ports       : clk      - clock
//                rst      - synchronous active-high reset
//                i_inc    - count one this cycle
//                o_count  - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= INIT;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline sequencing controller for the five-stage RV32I
//                core. Produces PC / IF/ID / ID/EX enables and flushes and
//                later-stage enables, resolving (highest priority first)
//                data-memory wait, taken-branch redirect, load-use hazard
//                and instruction-memory wait. A redirect that arrives while
//                the fetch is missing is latched and applied on the first
//                cycle the fetch completes with data memory idle.
//  Ports       : clk_i, rst_i            - clock, synchronous active-high reset
//                id_*                    - source registers of the ID instruction
//                ex_*                    - EX-stage load / branch information
//                imem_ready_i            - fetch data valid this cycle
//                dmem_busy_i             - data memory stalling
//                pc_*/redirect_pc_o      - PC load enable and redirect select
//                ifid_*/idex_*           - stage register enables / flushes
//                exmem_en_o, memwb_en_o  - later stage enables
//                stall_count_o           - saturating count of PC-hold cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic            id_uses_rs2_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            ex_mem_read_i,
    input  logic            ex_branch_taken_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            imem_ready_i,
    input  logic            dmem_busy_i,
    output logic            pc_en_o,
    output logic            pc_redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            ifid_en_o,
    output logic            ifid_flush_o,
    output logic            idex_en_o,
    output logic            idex_flush_o,
    output logic            exmem_en_o,
    output logic            memwb_en_o,
    output logic [31:0]     stall_count_o
);

    hz_state_e       r_state;
    hz_state_e       w_state_nxt;
    hz_state_e       w_eff_state;
    logic            r_pend;
    logic            w_pend_nxt;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] w_target_nxt;
    logic            w_load_use;

    assign w_load_use = load_use_hazard(ex_mem_read_i, ex_rd_i, id_rs1_i,
                                        id_rs2_i, id_uses_rs2_i);

    // DSTALL only freezes; once busy drops the controller behaves as the
    // state it was frozen in. r_pend remembers whether that was a pending
    // redirect, every other frozen state resumes as RUN.
    always_comb begin
        w_eff_state = r_state;
        if (r_state == DSTALL) begin
            w_eff_state = r_pend ? IMISS_REDIR : RUN;
        end
    end

    always_comb begin
        pc_en_o       = 1'b1;
        pc_redirect_o = 1'b0;
        redirect_pc_o = '0;
        ifid_en_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_en_o     = 1'b1;
        idex_flush_o  = 1'b0;
        exmem_en_o    = 1'b1;
        memwb_en_o    = 1'b1;
        w_state_nxt   = RUN;
        w_pend_nxt    = 1'b0;
        w_target_nxt  = r_target;

        if (dmem_busy_i) begin
            pc_en_o     = 1'b0;
            ifid_en_o   = 1'b0;
            idex_en_o   = 1'b0;
            exmem_en_o  = 1'b0;
            memwb_en_o  = 1'b0;
            w_state_nxt = DSTALL;
            w_pend_nxt  = (w_eff_state == IMISS_REDIR);
        end else if (ex_branch_taken_i) begin
            // Both younger instructions are wrong-path; a load-use on the
            // ID instruction is irrelevant because it is discarded here.
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            if (imem_ready_i) begin
                pc_redirect_o = 1'b1;
                redirect_pc_o = ex_target_i;
            end else begin
                pc_en_o      = 1'b0;
                w_target_nxt = ex_target_i;
                w_state_nxt  = IMISS_REDIR;
                w_pend_nxt   = 1'b1;
            end
        end else if (w_eff_state == IMISS_REDIR) begin
            // Everything younger than the redirect is wrong-path, so IF/ID
            // and ID/EX stay flushed and a load-use there is moot. The word
            // arriving with imem_ready_i is from the old path and dropped.
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            if (imem_ready_i) begin
                pc_redirect_o = 1'b1;
                redirect_pc_o = r_target;
            end else begin
                pc_en_o     = 1'b0;
                w_state_nxt = IMISS_REDIR;
                w_pend_nxt  = 1'b1;
            end
        end else if (w_load_use) begin
            pc_en_o      = 1'b0;
            ifid_en_o    = 1'b0;
            idex_flush_o = 1'b1;
        end else if (!imem_ready_i) begin
            pc_en_o      = 1'b0;
            ifid_flush_o = 1'b1;
            w_state_nxt  = IMISS;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= RUN;
            r_pend   <= 1'b0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pend   <= w_pend_nxt;
            r_target <= w_target_nxt;
        end
    end

    sat_counter #(
        .WIDTH (32),
        .INIT  (32'h0000_0000)
    ) u_stall_cnt (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_inc   (~pc_en_o),
        .o_count (stall_count_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. A rule-level model
//                (pending-redirect flag, latched target, stall count) gives
//                the expected controls every cycle; directed scenarios add
//                literal expectations, then randomized traffic follows.
//                A separate preloaded sat_counter covers saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic            rst_i;
    logic [4:0]      id_rs1_i, id_rs2_i, ex_rd_i;
    logic            id_uses_rs2_i, ex_mem_read_i, ex_branch_taken_i;
    logic [XLEN-1:0] ex_target_i;
    logic            imem_ready_i, dmem_busy_i;
    logic            pc_en_o, pc_redirect_o, ifid_en_o, ifid_flush_o;
    logic            idex_en_o, idex_flush_o, exmem_en_o, memwb_en_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic [31:0]     stall_count_o;
    logic [7:0]      dut_ctl;

    logic            sat_rst, sat_inc;
    logic [31:0]     sat_count;

    hazard_ctrl u_dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .id_uses_rs2_i     (id_uses_rs2_i),
        .ex_rd_i           (ex_rd_i),
        .ex_mem_read_i     (ex_mem_read_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .ex_target_i       (ex_target_i),
        .imem_ready_i      (imem_ready_i),
        .dmem_busy_i       (dmem_busy_i),
        .pc_en_o           (pc_en_o),
        .pc_redirect_o     (pc_redirect_o),
        .redirect_pc_o     (redirect_pc_o),
        .ifid_en_o         (ifid_en_o),
        .ifid_flush_o      (ifid_flush_o),
        .idex_en_o         (idex_en_o),
        .idex_flush_o      (idex_flush_o),
        .exmem_en_o        (exmem_en_o),
        .memwb_en_o        (memwb_en_o),
        .stall_count_o     (stall_count_o)
    );

    sat_counter #(
        .WIDTH (32),
        .INIT  (32'hFFFF_FFFE)
    ) u_sat (
        .clk     (clk_i),
        .rst     (sat_rst),
        .i_inc   (sat_inc),
        .o_count (sat_count)
    );

    // {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    assign dut_ctl = {pc_en_o, pc_redirect_o, ifid_en_o, ifid_flush_o,
                      idex_en_o, idex_flush_o, exmem_en_o, memwb_en_o};

    int n_total = 0;
    int n_pass  = 0;

    // Model state: is a redirect owed to the PC, where to, and the stall tally
    bit          m_pend   = 1'b0;
    logic [31:0] m_target = 32'h0;
    logic [31:0] m_count  = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected controls straight from the priority rules
    task automatic model_outputs(output logic [7:0] ctl, output logic [31:0] pc);
        bit lu;
        lu = ex_mem_read_i && (ex_rd_i != 5'd0) &&
             ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
        pc = 32'h0;
        if (dmem_busy_i) begin
            ctl = 8'b0000_0000;
        end else if (ex_branch_taken_i || m_pend) begin
            if (imem_ready_i) begin
                ctl = 8'b1111_1111;
                pc  = ex_branch_taken_i ? ex_target_i : m_target;
            end else begin
                ctl = 8'b0011_1111;
            end
        end else if (lu) begin
            ctl = 8'b0000_1111;
        end else if (!imem_ready_i) begin
            ctl = 8'b0011_1011;
        end else begin
            ctl = 8'b1010_1011;
        end
    endtask

    // Compare at the falling edge, inputs have been stable since rise+1
    task automatic settle();
        logic [7:0]  ctl;
        logic [31:0] pc;
        @(negedge clk_i);
        model_outputs(ctl, pc);
        if (!rst_i) begin
            check("model_ctl", {24'h0, dut_ctl}, {24'h0, ctl});
            check("model_redirect_pc", redirect_pc_o, pc);
            check("model_stall_count", stall_count_o, m_count);
        end
    endtask

    // Advance the model across the coming rising edge, then move past it
    task automatic commit();
        logic [7:0]  ctl;
        logic [31:0] pc;
        model_outputs(ctl, pc);
        if (rst_i) begin
            m_pend   = 1'b0;
            m_target = 32'h0;
            m_count  = 32'h0;
        end else begin
            if (!dmem_busy_i) begin
                if (ex_branch_taken_i && !imem_ready_i) begin
                    m_pend   = 1'b1;
                    m_target = ex_target_i;
                end else if (imem_ready_i) begin
                    m_pend = 1'b0;
                end
            end
            if (!ctl[7] && (m_count != 32'hFFFF_FFFF)) m_count = m_count + 32'd1;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input bit br, input logic [31:0] tgt, input bit rdy, input bit busy,
                         input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit u2);
        ex_branch_taken_i = br;
        ex_target_i       = tgt;
        imem_ready_i      = rdy;
        dmem_busy_i       = busy;
        ex_mem_read_i     = mr;
        ex_rd_i           = rd;
        id_rs1_i          = rs1;
        id_rs2_i          = rs2;
        id_uses_rs2_i     = u2;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 32'h0, rdy, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        rst_i   = 1'b1;
        sat_rst = 1'b1;
        sat_inc = 1'b0;
        idle(1'b1);
        settle();
        commit();
        rst_i   = 1'b0;
        sat_rst = 1'b0;

        // Reset state and counter preload
        settle();
        check("reset_ctl", {24'h0, dut_ctl}, 32'h0000_00AB);
        check("reset_redirect_pc", redirect_pc_o, 32'h0);
        check("reset_stall_count", stall_count_o, 32'h0);
        check("sat_preload", sat_count, 32'hFFFF_FFFE);
        sat_inc = 1'b1;
        commit();
        settle();
        check("sat_reach_max", sat_count, 32'hFFFF_FFFF);
        commit();
        settle();
        check("sat_hold_max", sat_count, 32'hFFFF_FFFF);
        sat_inc = 1'b0;
        commit();

        // Load-use: one bubble, counter 0 -> 1
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        settle();
        check("loaduse_ctl", {24'h0, dut_ctl}, 32'h0000_000F);
        check("loaduse_count_before", stall_count_o, 32'h0);
        commit();
        idle(1'b1);
        settle();
        check("loaduse_after_ctl", {24'h0, dut_ctl}, 32'h0000_00AB);
        check("loaduse_count_after", stall_count_o, 32'h1);
        commit();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        check("loaduse_x0_ctl", {24'h0, dut_ctl}, 32'h0000_00AB);
        commit();

        // Taken branch with fetch ready
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        check("branch_run_ctl", {24'h0, dut_ctl}, 32'h0000_00FF);
        check("branch_run_pc", redirect_pc_o, 32'h100);
        commit();

        // Branch during a four-cycle fetch miss
        idle(1'b0);
        settle();
        check("imiss_ctl", {24'h0, dut_ctl}, 32'h0000_003B);
        commit();
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        check("miss_branch_ctl", {24'h0, dut_ctl}, 32'h0000_003F);
        commit();
        idle(1'b0);
        for (int i = 0; i < 2; i++) begin
            settle();
            check("imiss_redir_ctl", {24'h0, dut_ctl}, 32'h0000_003F);
            commit();
        end
        idle(1'b1);
        settle();
        check("miss_redirect_ctl", {24'h0, dut_ctl}, 32'h0000_00FF);
        check("miss_redirect_pc", redirect_pc_o, 32'h200);
        commit();

        // Data-memory freeze during a pending redirect
        drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        commit();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, (i == 2), 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            settle();
            check("dstall_ctl", {24'h0, dut_ctl}, 32'h0000_0000);
            commit();
        end
        idle(1'b1);
        settle();
        check("dstall_resume_ctl", {24'h0, dut_ctl}, 32'h0000_00FF);
        check("dstall_resume_pc", redirect_pc_o, 32'h300);
        commit();

        // Branch and load-use together
        drive(1'b1, 32'h500, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        settle();
        check("priority_ctl", {24'h0, dut_ctl}, 32'h0000_00FF);
        check("priority_pc", redirect_pc_o, 32'h500);
        commit();

        // Reset while a redirect is pending
        drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        commit();
        idle(1'b0);
        rst_i = 1'b1;
        settle();
        commit();
        rst_i = 1'b0;
        idle(1'b1);
        settle();
        check("post_reset_ctl", {24'h0, dut_ctl}, 32'h0000_00AB);
        check("post_reset_pc", redirect_pc_o, 32'h0);
        check("post_reset_count", stall_count_o, 32'h0);
        commit();

        // Randomized traffic with narrow register indices to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(99, 0) < 15,
                  {$urandom_range(255, 0), 2'b00},
                  $urandom_range(99, 0) < 75,
                  $urandom_range(99, 0) < 12,
                  $urandom_range(99, 0) < 40,
                  5'($urandom_range(3, 0)),
                  5'($urandom_range(3, 0)),
                  5'($urandom_range(3, 0)),
                  $urandom_range(1, 0) == 1);
            rst_i = ($urandom_range(99, 0) < 2);
            settle();
            commit();
        end
        rst_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RV32I core. Each cycle it computes enable and flush controls for the PC register, the IF/ID register and the downstream stage registers. It resolves load-use hazards, taken-branch redirects, instruction-memory wait states and data-memory wait states. A small FSM records a redirect that arrives during an instruction fetch miss, so that no taken branch is lost.

## Interface
- XLEN, 32, address/PC width
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- id_rs1_i  in  5  rs1 of instruction in IF/ID
- id_rs2_i  in  5  rs2 of instruction in IF/ID
- id_uses_rs2_i  in  1  decoded instruction reads rs2 (R/S/B types)
- ex_rd_i  in  5  rd of instruction in ID/EX
- ex_mem_read_i  in  1  ID/EX instruction is a load
- ex_branch_taken_i  in  1  branch/jump in EX resolved taken
- ex_target_i  in  XLEN  redirect target from EX
- imem_ready_i  in  1  fetch data valid this cycle
- dmem_busy_i  in  1  data memory cannot complete this cycle
- pc_en_o  out  1  PC register load enable
- pc_redirect_o  out  1  PC mux selects redirect_pc_o
- redirect_pc_o  out  XLEN  redirect address
- ifid_en_o  out  1  IF/ID capture enable
- ifid_flush_o  out  1  IF/ID loads NOP
- idex_en_o  out  1  ID/EX capture enable
- idex_flush_o  out  1  ID/EX loads bubble
- exmem_en_o, memwb_en_o  out  1 each  later stage enables
- stall_count_o  out  32  saturating count of cycles with pc_en_o=0

## Operation
- States: RUN, IMISS, IMISS_REDIR, DSTALL.
- Priority, highest first: dmem_busy_i, branch redirect, load-use, imem not ready.
- Load-use: ex_mem_read_i & ex_rd_i!=0 & (ex_rd_i==id_rs1_i | (id_uses_rs2_i & ex_rd_i==id_rs2_i)).
- DSTALL (entered/held while dmem_busy_i): all enables 0, all flushes 0; everything freezes. Returns to RUN when busy drops. A pending redirect is retained and applied after the stall: resume IMISS_REDIR if that was the prior state.
- Taken branch, not in DSTALL: ifid_flush_o=1 and idex_flush_o=1.
  - If imem_ready_i is high: pc_en_o=1, pc_redirect_o=1, redirect_pc_o=ex_target_i, next state RUN.
  - If imem_ready_i is low: latch ex_target_i into the redirect register and go to IMISS_REDIR.
- Load-use (no branch, no dmem busy): pc_en_o=0, ifid_en_o=0, idex_flush_o=1, exmem/memwb enabled. Lasts exactly one cycle.
- IMISS (imem_ready_i low, no higher event): pc_en_o=0, ifid_flush_o=1, downstream enabled so older instructions drain. Leave to RUN when imem_ready_i rises.
- IMISS_REDIR: same outputs as IMISS, with younger stages kept flushed.
  - When imem_ready_i rises, discard the fetched word: ifid_flush_o=1.
  - Same cycle: pc_en_o=1, pc_redirect_o=1, redirect_pc_o=latched target, next state RUN.
  - A newer taken branch in this state overwrites the latched target.
- RUN with no event: all enables 1, flushes 0, pc_redirect_o=0.
- stall_count_o increments when pc_en_o=0 and saturates at 0xFFFF_FFFF.

## Timing
- All outputs are combinational from the inputs and the current state.
- The state, latched target and counter update on the clk_i edge.
- Reset:
  - State=RUN, latched target=0, stall_count_o=0.
  - All enables 1, all flushes 0, pc_redirect_o=0, redirect_pc_o=0.
- A flush asserted in cycle N puts a bubble in the target register at edge N+1.
- Redirect latency: the target reaches the PC at the first edge where imem_ready_i=1 and dmem_busy_i=0.
- Load-use costs one bubble. Back-to-back load-use is re-evaluated each cycle.
- A branch plus load-use in the same cycle is handled as a branch only; the dependent instruction is flushed anyway.
- rst_i mid-miss: the pending redirect is dropped and the state returns to RUN next edge.

## Structure
- The shared core package holds:
  - the `hz_state_e` enum (RUN, IMISS, IMISS_REDIR, DSTALL)
  - XLEN
  - the NOP encoding 32'h0000_0013 used by the stage registers on flush
- Sub-module: `sat_counter` (width parameter, inc, synchronous reset) for stall_count_o.

## Test plan
- Load-use:
  - Stimulus: ex_mem_read_i=1, ex_rd_i=5, id_rs1_i=5.
  - Response: one cycle of pc_en_o=0, ifid_en_o=0, idex_flush_o=1; stall_count_o goes from 0 to 1.
  - Same stimulus with ex_rd_i=0: no stall.
- Branch in RUN:
  - Stimulus: ex_branch_taken_i=1, ex_target_i=0x100, imem_ready_i=1.
  - Response: pc_redirect_o=1, redirect_pc_o=0x100, ifid_flush_o=idex_flush_o=1.
- Branch during miss:
  - Stimulus: imem_ready_i=0 for 4 cycles, taken branch to 0x200 in cycle 2.
  - Response: state goes to IMISS_REDIR. At the ready cycle, redirect_pc_o=0x200, pc_en_o=1, ifid_flush_o=1.
- Dmem freeze:
  - Stimulus: dmem_busy_i=1 for 3 cycles during IMISS_REDIR.
  - Response: all enables 0. The latched target is retained and applied after busy drops and imem_ready_i=1.
- Priority:
  - Stimulus: branch and load-use in the same cycle.
  - Response: pc_en_o=1, pc_redirect_o=1, both flushes asserted.
- Reset/saturation:
  - Stimulus: rst_i pulse in IMISS_REDIR, then a preloaded counter at max with a stall.
  - Response: after reset, state RUN and no redirect. The preloaded counter holds 0xFFFF_FFFF.
